// File: rtl/beep_pkg.sv
// -----------------------------------------------------------------------------
// beep_pkg
// Shared definitions for the beep burst generator:
//   - beep_state_e : burst FSM states (IDLE / ON / OFF)
//   - ms_to_cyc    : clock cycles in a millisecond duration
//   - hz_to_half_cyc : clock cycles in half a tone period
//   - timer_width  : phase-timer width that covers the longer phase
// All arithmetic is 32-bit unsigned and truncating, so results match a
// straightforward integer evaluation of the same expressions.
// -----------------------------------------------------------------------------
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } beep_state_e;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_freq,
                                              input int unsigned ms);
        return (clk_freq / 32'd1000) * ms;
    endfunction

    function automatic int unsigned hz_to_half_cyc(input int unsigned clk_freq,
                                                   input int unsigned hz);
        return clk_freq / (32'd2 * hz);
    endfunction

    // $clog2 of the longer phase; never narrower than one bit so that a
    // degenerate one-cycle phase still gets a legal vector.
    function automatic int unsigned timer_width(input int unsigned on_cyc,
                                                input int unsigned off_cyc);
        int unsigned longest;
        longest = (on_cyc > off_cyc) ? on_cyc : off_cyc;
        return (longest <= 32'd2) ? 32'd1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/beep_tone_div.sv
// -----------------------------------------------------------------------------
// beep_tone_div
// Square-wave tone generator for a passive buzzer. While en is high the
// registered output toggles every HALF_CYC clocks, starting high on the first
// enabled cycle. While en is low the divider is held at phase 0 and the output
// is 0, so every new enable restarts the tone from the same phase.
//
// Ports:
//   sys_clk  in  1  clock
//   sys_rst  in  1  synchronous active-high reset
//   en       in  1  run the divider; low restarts it from phase 0
//   tone     out 1  registered square wave
// -----------------------------------------------------------------------------
module beep_tone_div
    import beep_pkg::*;
#(
    parameter int unsigned HALF_CYC = 32'd9259
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tone
);

    localparam int unsigned HALF_EFF = (HALF_CYC < 32'd1) ? 32'd1 : HALF_CYC;
    localparam int unsigned DIV_W    = (HALF_EFF <= 32'd2) ? 32'd1 : $clog2(HALF_EFF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_EFF - 32'd1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             run_q, run_d;
    logic             tone_q, tone_d;

    always_comb begin
        div_d  = div_q;
        run_d  = run_q;
        tone_d = tone_q;
        if (!en) begin
            div_d  = '0;
            run_d  = 1'b0;
            tone_d = 1'b0;
        end else if (!run_q) begin
            // first enabled cycle: start the half period high
            div_d  = '0;
            run_d  = 1'b1;
            tone_d = 1'b1;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            tone_d = ~tone_q;
        end else begin
            div_d  = div_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q  <= '0;
            run_q  <= 1'b0;
            tone_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            run_q  <= run_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/beep_burst_gen.sv
// -----------------------------------------------------------------------------
// beep_burst_gen
// Buzzer burst driver. A one-cycle start with a non-zero count launches
// `count` beeps of ON_MS each separated by OFF_MS gaps (no gap after the last
// beep). busy covers the whole burst, done pulses for one cycle right after
// the final ON cycle. Requests while busy, and zero-count requests, are
// dropped. All outputs are registered.
//
// Configuration macro: BEEP_PASSIVE_TONE_EN
//   defined   - passive buzzer: beep carries a TONE_HZ square wave during ON
//               (beep_tone_div instantiated)
//   undefined - active buzzer: beep is a steady 1 during ON
//
// Ports:
//   sys_clk  in  1      clock
//   sys_rst  in  1      synchronous active-high reset
//   start    in  1      one-cycle request pulse
//   count    in  CNT_W  number of beeps, sampled with start in IDLE
//   busy     out 1      burst in progress
//   done     out 1      one-cycle pulse at burst completion
//   beep     out 1      buzzer drive, 1 = sound
// -----------------------------------------------------------------------------
module beep_burst_gen
    import beep_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 32'd50_000_000,
    parameter int unsigned TONE_HZ  = 32'd2_700,
    parameter int unsigned ON_MS    = 32'd100,
    parameter int unsigned OFF_MS   = 32'd100,
    parameter int unsigned CNT_W    = 32'd4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             beep
);

    localparam int unsigned ON_CYC  = ms_to_cyc(CLK_FREQ, ON_MS);
    localparam int unsigned OFF_CYC = ms_to_cyc(CLK_FREQ, OFF_MS);
    localparam int unsigned TMR_W   = timer_width(ON_CYC, OFF_CYC);

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYC - 32'd1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYC - 32'd1);

    // Zero-length phases or a zero tone frequency would make the terminal
    // counts wrap; reject such configurations at elaboration.
    if (ON_CYC == 32'd0 || OFF_CYC == 32'd0 || TONE_HZ == 32'd0 || CNT_W == 32'd0)
    begin : g_param_check
        $error("beep_burst_gen: ON/OFF durations, TONE_HZ and CNT_W must be non-zero");
    end

    beep_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (count != '0)) begin
                    remaining_d = count;
                    tmr_d       = '0;
                    state_d     = ST_ON;
                    busy_d      = 1'b1;
                end
            end
            ST_ON: begin
                if (tmr_q == ON_LAST) begin
                    // remaining is never 0 here, so the decrement cannot wrap
                    remaining_d = remaining_q - 1'b1;
                    tmr_d       = '0;
                    if (remaining_d == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (tmr_q == OFF_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_ON;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tmr_d       = '0;
                remaining_d = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef BEEP_PASSIVE_TONE_EN
    localparam int unsigned HALF_CYC = hz_to_half_cyc(CLK_FREQ, TONE_HZ);

    logic tone;

    // The divider runs on the next state so its registered output lines up
    // with the first ON cycle and drops on the same edge that leaves ON.
    beep_tone_div #(
        .HALF_CYC (HALF_CYC)
    ) u_tone_div (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (state_d == ST_ON),
        .tone    (tone)
    );

    assign beep = tone;
`else
    logic beep_q, beep_d;

    always_comb begin
        beep_d = (state_d == ST_ON);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            beep_q <= 1'b0;
        end else begin
            beep_q <= beep_d;
        end
    end

    assign beep = beep_q;
`endif

endmodule

// File: tb/tb_beep_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_beep_burst_gen
// Bench for beep_burst_gen with CLK_FREQ=1 MHz, ON_MS=1, OFF_MS=2,
// TONE_HZ=100 kHz (ON 1000 cycles, OFF 2000 cycles, half tone period 5).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_beep_burst_gen;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned TONE_HZ  = 100_000;
    localparam int unsigned ON_MS    = 1;
    localparam int unsigned OFF_MS   = 2;
    localparam int unsigned CNT_W    = 4;

    localparam int ON_CYC  = 1000;
    localparam int OFF_CYC = 2000;
    localparam int HALF    = 5;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             start   = 1'b0;
    logic [CNT_W-1:0] count   = '0;
    logic             busy;
    logic             done;
    logic             beep;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int busy_cyc;
        int bursts;
    } exp_t;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        int               busy_cyc;
        int               bursts;
    } vec_t;

    exp_t sb_q[$];

    beep_burst_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TONE_HZ  (TONE_HZ),
        .ON_MS    (ON_MS),
        .OFF_MS   (OFF_MS),
        .CNT_W    (CNT_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .beep    (beep)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs t cycles after the edge that sampled a start with count c.
    function automatic void model(input int c, input int t,
                                  output logic eb, output logic ed, output logic ep);
        int tb;
        int p;
        tb = (c == 0) ? 0 : c * ON_CYC + (c - 1) * OFF_CYC;
        eb = (c != 0) && (t >= 1) && (t <= tb);
        ed = (c != 0) && (t == tb + 1);
        ep = 1'b0;
        if (eb) begin
            p = (t - 1) % (ON_CYC + OFF_CYC);
            if (p < ON_CYC) begin
`ifdef BEEP_PASSIVE_TONE_EN
                ep = (((p / HALF) % 2) == 0);
`else
                ep = 1'b1;
`endif
            end
        end
    endfunction

    // Burst-level scoreboard: measures each burst and compares at done.
    int   mon_len   = 0;
    int   mon_burst = 0;
    int   low_run   = 1000;
    logic prev_busy = 1'b0;
    logic prev_beep = 1'b0;

    always @(negedge sys_clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            mon_len++;
            if (beep === 1'b1 && prev_beep !== 1'b1 && (!prev_busy || low_run >= 2 * HALF))
                mon_burst++;
        end
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb unexpected done: got done=1, expected no pending burst");
            end else begin
                e = sb_q.pop_front();
                check("sb busy length", mon_len, e.busy_cyc);
                check("sb burst count", mon_burst, e.bursts);
            end
        end
        if (busy !== 1'b1) begin
            mon_len   = 0;
            mon_burst = 0;
        end
        if (beep === 1'b1) low_run = 0;
        else if (low_run < 100000) low_run++;
        prev_busy = (busy === 1'b1);
        prev_beep = beep;
    end

    // Start a burst and compare every cycle of the window against the model.
    // Optionally drive a second start after the sample at cycle extra_at.
    task automatic run_trace(input logic [CNT_W-1:0] cnt, input int exp_busy, input int exp_bursts,
                             input int window, input int extra_at, input logic [CNT_W-1:0] extra_cnt);
        int   err_b, err_d, err_p;
        int   first_b, first_d, first_p;
        logic eb, ed, ep;
        logic ab, ad, ap;
        err_b = 0; err_d = 0; err_p = 0;
        first_b = -1; first_d = -1; first_p = -1;
        ab = 1'b0; ad = 1'b0; ap = 1'b0;
        @(negedge sys_clk);
        count = cnt;
        start = 1'b1;
        if (cnt != '0) sb_q.push_back('{exp_busy, exp_bursts});
        for (int t = 1; t <= window; t++) begin
            @(negedge sys_clk);
            model(int'(cnt), t, eb, ed, ep);
            if (busy !== eb) begin err_b++; if (first_b < 0) begin first_b = t; ab = busy; end end
            if (done !== ed) begin err_d++; if (first_d < 0) begin first_d = t; ad = done; end end
            if (beep !== ep) begin err_p++; if (first_p < 0) begin first_p = t; ap = beep; end end
            if (t == extra_at) begin
                start = 1'b1;
                count = extra_cnt;
            end else begin
                start = 1'b0;
                count = '0;
            end
        end
        n_tests += 3;
        if (err_b != 0) begin
            n_fail++;
            $display("FAIL busy trace count=%0d: %0d bad cycles, first t=%0d got %b expected %b",
                     cnt, err_b, first_b, ab, ~ab);
        end
        if (err_d != 0) begin
            n_fail++;
            $display("FAIL done trace count=%0d: %0d bad cycles, first t=%0d got %b expected %b",
                     cnt, err_d, first_d, ad, ~ad);
        end
        if (err_p != 0) begin
            n_fail++;
            $display("FAIL beep trace count=%0d: %0d bad cycles, first t=%0d got %b expected %b",
                     cnt, err_p, first_p, ap, ~ap);
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   n_done;
        bit   seen;

        vecs[0] = '{4'd3,  7000,  3};
        vecs[1] = '{4'd0,  0,     0};
        vecs[2] = '{4'd1,  1000,  1};
        vecs[3] = '{4'd2,  4000,  2};
        vecs[4] = '{4'd15, 43000, 15};

        // reset state
        repeat (3) @(negedge sys_clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset beep", beep, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // table-driven bursts, including count=0 and the maximum count
        for (int i = 0; i < 5; i++) begin
            run_trace(vecs[i].cnt, vecs[i].busy_cyc, vecs[i].bursts,
                      (vecs[i].busy_cyc == 0) ? 200 : vecs[i].busy_cyc + 20, 0, '0);
        end

        // second start at cycle 500 while busy is dropped
        run_trace(4'd2, 4000, 2, 4020, 500, 4'd5);

        // start in the same cycle as done is dropped
        run_trace(4'd1, 1000, 1, 1100, 1000, 4'd3);

        // start in the cycle after done is accepted
        run_trace(4'd1, 1000, 1, 1001, 1001, 4'd2);
        sb_q.push_back('{4000, 2});
        @(negedge sys_clk);
        start = 1'b0;
        count = '0;
        check("start after done busy", busy, 1);
        seen = 1'b0;
        for (int t = 0; t < 4100 && !seen; t++) begin
            @(negedge sys_clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("start after done completes", seen, 1);

        // reset in the middle of a count=4 burst
        @(negedge sys_clk);
        count = 4'd4;
        start = 1'b1;
        sb_q.push_back('{4 * ON_CYC + 3 * OFF_CYC, 4});
        for (int t = 1; t <= 1500; t++) begin
            @(negedge sys_clk);
            start = 1'b0;
            count = '0;
        end
        check("pre-reset busy", busy, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sb_q.delete();
        check("mid-burst reset busy", busy, 0);
        check("mid-burst reset beep", beep, 0);
        check("mid-burst reset done", done, 0);
        n_done = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge sys_clk);
            if (done === 1'b1) n_done++;
        end
        check("no done after reset", n_done, 0);
        run_trace(4'd1, 1000, 1, 1020, 0, '0);

        @(negedge sys_clk);
        check("scoreboard drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
